// File: rtl/cpu8227_pkg.sv
// Shared types for the 8227 board harness: run-mode encoding and trace entry layout.
package cpu8227_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    HALT = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } run_state_t;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/btn_conditioner.sv
// Two-flop synchroniser plus debounce for one raw board input; level_o only
// follows the synced input after it has differed for DEBOUNCE_CYC cycles.
module btn_conditioner #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      if (sync_q[1] != level_q) begin
        // Flip on the edge where the new level completes its stable run.
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/cpu_step_monitor.sv
// Board-side harness for the 8227 core: button conditioning, halt/step/run
// clock enable generation, NMI/IRQ requests and a scrollable bus-cycle trace.
module cpu_step_monitor #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 8,
  parameter int DEBOUNCE_CYC = 4,
  parameter int RUN_DIV      = 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       run_sw,
  input  logic                       step_btn,
  input  logic                       nmi_btn,
  input  logic                       irq_btn,
  input  logic                       freeze,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_dout,
  input  logic                       cpu_rw,
  input  logic [$clog2(DEPTH)-1:0]   view_idx,
  output logic                       cpu_ce,
  output logic                       nmi_req,
  output logic                       irq_req,
  output logic [ADDR_W-1:0]          view_addr,
  output logic [DATA_W-1:0]          view_data,
  output logic                       view_rw,
  output logic                       view_valid,
  output logic [$clog2(DEPTH):0]     trace_count,
  output logic [1:0]                 run_state
);

  import cpu8227_pkg::*;

  localparam int PW      = $clog2(DEPTH);
  localparam int CNTW    = PW + 1;
  localparam int DIVW    = $clog2(RUN_DIV) + 1;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(RUN_DIV - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

  logic run_lvl, step_lvl, nmi_lvl, irq_lvl;

  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run  (.clk(clk), .nrst(nrst), .btn_i(run_sw),   .level_o(run_lvl));
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step (.clk(clk), .nrst(nrst), .btn_i(step_btn), .level_o(step_lvl));
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_nmi  (.clk(clk), .nrst(nrst), .btn_i(nmi_btn),  .level_o(nmi_lvl));
  btn_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_irq  (.clk(clk), .nrst(nrst), .btn_i(irq_btn),  .level_o(irq_lvl));

  run_state_t      state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic            ce_q, ce_d;
  logic            step_prev_q, nmi_prev_q;
  logic            nmi_q, nmi_d;
  logic            step_rise, nmi_rise;

  assign step_rise = step_lvl & ~step_prev_q;
  assign nmi_rise  = nmi_lvl & ~nmi_prev_q;

  always_comb begin
    state_d = state_q;
    ce_d    = 1'b0;
    div_d   = '0;
    case (state_q)
      HALT: begin
        if (run_lvl) begin
          state_d = RUN;
        end else if (step_rise) begin
          state_d = STEP;
          ce_d    = 1'b1;
        end
      end
      STEP: state_d = HALT;
      RUN: begin
        if (!run_lvl) begin
          state_d = HALT;
        end else if (div_q == DIV_LAST) begin
          ce_d = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = HALT;
    endcase
  end

  // A fresh edge outranks the clear so a press during a cpu_ce cycle is kept.
  always_comb begin
    nmi_d = nmi_q;
    if (nmi_rise)    nmi_d = 1'b1;
    else if (ce_q)   nmi_d = 1'b0;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= HALT;
      div_q       <= '0;
      ce_q        <= 1'b0;
      step_prev_q <= 1'b0;
      nmi_prev_q  <= 1'b0;
      nmi_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      ce_q        <= ce_d;
      step_prev_q <= step_lvl;
      nmi_prev_q  <= nmi_lvl;
      nmi_q       <= nmi_d;
    end
  end

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q;
  logic [CNTW-1:0]    count_q;
  logic [PW-1:0]      rd_idx;
  logic [ENTRY_W-1:0] rd_entry;
  logic               we, rd_valid;
  logic [ADDR_W-1:0]  view_addr_q;
  logic [DATA_W-1:0]  view_data_q;
  logic               view_rw_q, view_valid_q;

  assign we       = ce_q & ~freeze;
  assign rd_idx   = wr_ptr_q - PW'(1) - view_idx;
  assign rd_entry = mem_q[rd_idx];
  assign rd_valid = {1'b0, view_idx} < count_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= {cpu_rw, cpu_addr, cpu_dout};
  end

  // Read uses the pre-write pointer, so a same-cycle write shows up one cycle later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q     <= '0;
      count_q      <= '0;
      view_addr_q  <= '0;
      view_data_q  <= '0;
      view_rw_q    <= 1'b0;
      view_valid_q <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (count_q != CNT_FULL) count_q <= count_q + 1'b1;
      end
      view_valid_q <= rd_valid;
      view_rw_q    <= rd_valid ? rd_entry[ENTRY_W-1] : 1'b0;
      view_addr_q  <= rd_valid ? rd_entry[DATA_W +: ADDR_W] : '0;
      view_data_q  <= rd_valid ? rd_entry[DATA_W-1:0] : '0;
    end
  end

  assign cpu_ce      = ce_q;
  assign nmi_req     = nmi_q;
  assign irq_req     = irq_lvl;
  assign view_addr   = view_addr_q;
  assign view_data   = view_data_q;
  assign view_rw     = view_rw_q;
  assign view_valid  = view_valid_q;
  assign trace_count = count_q;
  assign run_state   = state_q;

endmodule

// File: tb/tb_cpu_step_monitor.sv
// Directed bench for cpu_step_monitor (DEBOUNCE_CYC=4, RUN_DIV=3, DEPTH=8).
module tb_cpu_step_monitor;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        run_sw = 1'b0, step_btn = 1'b0, nmi_btn = 1'b0, irq_btn = 1'b0;
  logic        freeze = 1'b0;
  logic [15:0] cpu_addr = 16'h0200;
  logic [7:0]  cpu_dout = 8'h00;
  logic        cpu_rw = 1'b0;
  logic [2:0]  view_idx = 3'd0;
  logic        cpu_ce, nmi_req, irq_req, view_rw, view_valid;
  logic [15:0] view_addr;
  logic [7:0]  view_data;
  logic [3:0]  trace_count;
  logic [1:0]  run_state;

  cpu_step_monitor #(
    .ADDR_W(16), .DATA_W(8), .DEPTH(8), .DEBOUNCE_CYC(4), .RUN_DIV(3)
  ) dut (
    .clk(clk), .nrst(nrst), .run_sw(run_sw), .step_btn(step_btn),
    .nmi_btn(nmi_btn), .irq_btn(irq_btn), .freeze(freeze),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rw(cpu_rw),
    .view_idx(view_idx), .cpu_ce(cpu_ce), .nmi_req(nmi_req), .irq_req(irq_req),
    .view_addr(view_addr), .view_data(view_data), .view_rw(view_rw),
    .view_valid(view_valid), .trace_count(trace_count), .run_state(run_state)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int k    = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", tag, act, exp, k, $time);
    end
  endtask

  // Bus stimulus is a function of k so trace contents are easy to predict.
  task automatic drive();
    cpu_addr = 16'h0200 + 16'(k);
    cpu_dout = 8'(k);
    cpu_rw   = k[0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
    drive();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, ce_edge, kk;
    bit found;

    #2;
    chk("rst_ce", cpu_ce, 0);
    chk("rst_nmi", nmi_req, 0);
    chk("rst_irq", irq_req, 0);
    chk("rst_valid", view_valid, 0);
    chk("rst_count", trace_count, 0);
    chk("rst_state", run_state, 0);
    chk("rst_vaddr", view_addr, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    ticks(3);

    // Single step: one ce pulse 7 edges after the raw press.
    k = 0; drive();
    step_btn = 1'b1;
    pulses = 0; ce_edge = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ce) begin pulses++; ce_edge = k; end
    end
    chk("step_pulses", pulses, 1);
    chk("step_edge", ce_edge, 7);
    chk("step_state", run_state, 0);
    chk("step_count", trace_count, 1);
    step_btn = 1'b0;
    ticks(10);
    view_idx = 3'd0; tick();
    chk("step_valid", view_valid, 1);
    chk("step_vaddr", view_addr, 16'h0207);
    chk("step_vdata", view_data, 8'h07);
    chk("step_vrw", view_rw, 1);
    view_idx = 3'd1; tick();
    chk("inv_valid", view_valid, 0);
    chk("inv_vaddr", view_addr, 0);

    // Glitch shorter than the debounce window.
    step_btn = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 3) step_btn = 1'b0;
      if (cpu_ce) pulses++;
    end
    chk("glitch_pulses", pulses, 0);
    chk("glitch_state", run_state, 0);

    // Free run, ce every 3rd cycle starting at edge 10.
    k = 0; drive();
    run_sw = 1'b1;
    for (int i = 1; i <= 36; i++) begin
      tick();
      chk("run_ce", cpu_ce, (k >= 10 && (k - 10) % 3 == 0) ? 1 : 0);
      if (k == 6) chk("run_state6", run_state, 0);
      if (k == 7) chk("run_state7", run_state, 1);
    end
    chk("run_count", trace_count, 8);

    // Frozen: scan all entries, newest first, descending by 3.
    freeze = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      view_idx = 3'(i);
      tick();
      if (cpu_ce) pulses++;
      kk = 34 - 3 * i;
      chk("scan_valid", view_valid, 1);
      chk("scan_vaddr", view_addr, 16'h0200 + 16'(kk));
      chk("scan_vdata", view_data, 8'(kk));
      chk("scan_vrw", view_rw, kk % 2);
    end
    chk("frz_pulses", pulses, 3);
    chk("frz_count", trace_count, 8);

    // Resume: write at edge 47; same-cycle view shows prior newest.
    freeze = 1'b0;
    view_idx = 3'd0;
    ticks(3);
    chk("wr_view_same", view_addr, 16'h0222);
    tick();
    chk("wr_view_next", view_addr, 16'h022E);
    chk("wr_view_data", view_data, 8'h2E);
    chk("wr_view_rw", view_rw, 0);
    view_idx = 3'd1; tick();
    chk("resume_idx1", view_addr, 16'h0222);
    view_idx = 3'd7; tick();
    chk("resume_idx7", view_addr, 16'h0210);
    chk("resume_count", trace_count, 8);
    run_sw = 1'b0;
    ticks(10);
    chk("halt_state", run_state, 0);

    // NMI: set on debounced edge, held until the end of a step cycle.
    k = 0;
    nmi_btn = 1'b1;
    ticks(6);
    chk("nmi_early", nmi_req, 0);
    tick();
    chk("nmi_set", nmi_req, 1);
    ticks(15);
    chk("nmi_hold", nmi_req, 1);
    k = 0;
    step_btn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (k == 7) begin
        chk("nmi_step_ce", cpu_ce, 1);
        chk("nmi_in_ce", nmi_req, 1);
      end
      if (k == 8) chk("nmi_clr", nmi_req, 0);
    end
    step_btn = 1'b0;
    ticks(10);
    chk("nmi_noretrig", nmi_req, 0);
    nmi_btn = 1'b0;

    // IRQ follows the debounced level, DEBOUNCE_CYC+2 edges.
    k = 0;
    irq_btn = 1'b1;
    ticks(5);
    chk("irq_early", irq_req, 0);
    tick();
    chk("irq_set", irq_req, 1);
    irq_btn = 1'b0;
    ticks(6);
    chk("irq_clr", irq_req, 0);

    // Asynchronous reset during a RUN ce pulse.
    run_sw = 1'b1;
    view_idx = 3'd0;
    ticks(12);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!found) begin
        tick();
        if (cpu_ce) found = 1'b1;
      end
    end
    chk("ce_wait", found, 1);
    chk("pre_rst_valid", view_valid, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_ce", cpu_ce, 0);
    chk("arst_nmi", nmi_req, 0);
    chk("arst_count", trace_count, 0);
    chk("arst_valid", view_valid, 0);
    chk("arst_state", run_state, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    k = 0;
    ticks(6);
    chk("post_rst_halt", run_state, 0);
    tick();
    chk("post_rst_run", run_state, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/cpu_step_monitor.md
Name: cpu_step_monitor

Overview:
- Parametrised board-side harness for the 8227 CPU core.
- Conditions raw breakout-board buttons: step, NMI and IRQ.
- Generates the CPU clock enable in halt, single-step or free-run mode.
- Records each executed bus cycle into a circular trace buffer that the display logic can scroll. The buffer replaces direct wiring of buses to LEDs and seven-segment displays.

Parameters:
- ADDR_W, 16, CPU address bus width
- DATA_W, 8, CPU data bus width
- DEPTH, 8, trace buffer entries (power of 2, >=2)
- DEBOUNCE_CYC, 4, consecutive stable cycles required to accept a button level change (>=1)
- RUN_DIV, 1, free-run enable period in clk cycles (>=1; 1 = every cycle)

Ports:
- clk  in  1  system clock (single clock domain)
- nrst  in  1  asynchronous active-low reset
- run_sw  in  1  raw run/halt switch, asynchronous; 1 = free run
- step_btn  in  1  raw single-step button, asynchronous
- nmi_btn  in  1  raw NMI button, asynchronous
- irq_btn  in  1  raw IRQ button, asynchronous
- freeze  in  1  synchronous; 1 = stop trace writes
- cpu_addr  in  ADDR_W  CPU address bus
- cpu_dout  in  DATA_W  CPU data bus output
- cpu_rw  in  1  CPU read(1)/write(0)
- view_idx  in  $clog2(DEPTH)  trace entry to display; 0 = newest
- cpu_ce  out  1  CPU clock enable
- nmi_req  out  1  active-high NMI request to CPU
- irq_req  out  1  active-high IRQ level to CPU
- view_addr  out  ADDR_W  selected entry address
- view_data  out  DATA_W  selected entry data
- view_rw  out  1  selected entry rw
- view_valid  out  1  selected entry holds data
- trace_count  out  $clog2(DEPTH)+1  valid entries, saturating at DEPTH
- run_state  out  2  current mode state encoding

Behaviour:
- Reset (nrst low, asynchronous): all outputs 0, state HALT, buffer pointers/count 0, debounced levels 0, divider 0. Buffer contents need not be cleared; view_valid gates them.
- Input conditioning, per button and run_sw:
  - 2-flop synchroniser.
  - Debounce counter runs while the synced level differs from the debounced level; it clears whenever they match.
  - Debounced level flips at the edge where the differing level has held DEBOUNCE_CYC cycles.
  - Raw change to debounced change is DEBOUNCE_CYC+2 edges. run_sw uses the same path.
- State machine (run_state: HALT=0, RUN=1, STEP=2):
  - HALT: debounced run=1 -> RUN. Debounced step rising edge -> STEP.
  - STEP: cpu_ce=1 for exactly this one cycle -> HALT.
  - RUN: cpu_ce=1 when the divider equals RUN_DIV-1; the divider wraps to 0. Debounced run=0 -> HALT; divider clears and no further cpu_ce is issued.
  - Step edges while in RUN or STEP are ignored, not queued.
  - Run and step edge in the same cycle from HALT: RUN wins.
- cpu_ce is registered. A step press gives one cpu_ce cycle, DEBOUNCE_CYC+3 edges after the raw rise.
- NMI:
  - A debounced nmi rising edge sets nmi_req.
  - nmi_req clears at the end of the next cpu_ce cycle.
  - A new edge in that same cycle wins, so nmi_req stays set.
  - Holding the button does not retrigger.
- IRQ: irq_req = debounced irq level (level-sensitive).
- Trace write:
  - At each edge where cpu_ce=1 and freeze=0, {cpu_rw, cpu_addr, cpu_dout} is written at wr_ptr.
  - wr_ptr increments modulo DEPTH. trace_count increments, saturating at DEPTH.
  - Once full, the oldest entry is overwritten.
- Trace read:
  - Entry = (wr_ptr-1-view_idx) mod DEPTH.
  - Outputs are registered, 1-cycle latency.
  - view_valid = (view_idx < trace_count). When invalid, view_addr/data/rw are 0.
  - A write and a view of index 0 in the same cycle: the view shows the pre-write newest entry; the new entry appears on the following cycle.
- Reset mid-step or mid-run: cpu_ce drops immediately (asynchronous), and pending NMI and trace are cleared.

Decomposition:
- Shared package cpu8227_pkg:
  - run_state_t enum (HALT/RUN/STEP).
  - trace_entry_t packed struct {rw, addr, data}, parametrised via package localparams matching the 8227 widths (ADDR_W=16, DATA_W=8).
- Sub-module btn_conditioner (sync + debounce, parameter DEBOUNCE_CYC), instantiated four times.

Test Plan:
- Reset, then hold step_btn high 20 cycles (DEBOUNCE_CYC=4) -> exactly one cpu_ce pulse at edge 7 after the press; run_state returns to HALT; trace_count=1; view_idx=0 shows the applied addr/data.
- step_btn glitch high for 3 cycles, then low -> no cpu_ce, state remains HALT.
- run_sw=1, RUN_DIV=3, cpu_addr incrementing from 16'h0200, 30 cycles -> cpu_ce every 3rd cycle; trace_count saturates at 8; view_idx 0..7 yields a descending address sequence; view_idx 0 is newest.
- run_sw=1 and freeze=1 -> cpu_ce continues but trace_count and contents are unchanged. Dropping freeze resumes writes at the prior wr_ptr.
- nmi_btn pressed in HALT -> nmi_req=1 and stays high until a step press; it clears after that cpu_ce cycle. Holding the button produces no second request.
- nrst asserted mid-RUN -> cpu_ce, nmi_req, trace_count and view_valid go 0 asynchronously; after release, run_state=HALT until the debounced run is seen again.
